// File: rtl/tb_unit.sv
// Viterbi traceback unit: assembles a 256-bit survivor frame every 8 columns and
// traces back 8 stages from best_state. Optional TB_OVERRUN_CNT_EN adds ovr_cnt.
module tb_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [4:0]  best_state,
    input  logic        dec_ready,
    output logic        dec_valid,
    output logic [7:0]  dec_bits,
    output logic [4:0]  end_state,
`ifdef TB_OVERRUN_CNT_EN
    output logic [7:0]  ovr_cnt,
`endif
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, TRACE, HOLD} state_t;

    state_t       state;
    logic [2:0]   col;
    logic [2:0]   step;
    logic [223:0] cap_bank;
    logic [255:0] trace_bank;
    logic [4:0]   tb_state;
    logic [7:0]   dec_int;

    logic         hist_bit;
    logic [4:0]   next_tb_state;
    logic         out_free;
    logic         last_stage;
    logic         handoff;
    logic         frame_drop;

    // Bit h[s][k] lives at s*8+k, so {tb_state, step} indexes it directly.
    always_comb begin
        hist_bit      = trace_bank[{tb_state, step}];
        next_tb_state = {hist_bit, tb_state[4:1]};
        out_free      = !dec_valid || dec_ready;
        last_stage    = (state == TRACE) && (step == 3'd7);
        handoff       = (col == 3'd7) && ((state == IDLE) || (last_stage && out_free));
        frame_drop    = (col == 3'd7) && !handoff;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            col        <= 3'd0;
            step       <= 3'd0;
            cap_bank   <= '0;
            trace_bank <= '0;
            tb_state   <= 5'd0;
            dec_int    <= 8'd0;
            dec_valid  <= 1'b0;
            dec_bits   <= 8'd0;
            end_state  <= 5'd0;
            overrun    <= 1'b0;
`ifdef TB_OVERRUN_CNT_EN
            ovr_cnt    <= 8'd0;
`endif
        end else begin
            col <= col + 3'd1;
            // Column 7 is never stored: it goes straight into the trace bank.
            if (col != 3'd7)
                cap_bank[{col, 5'd0} +: 32] <= data_in;

            if (dec_valid && dec_ready)
                dec_valid <= 1'b0;

            if (frame_drop) begin
                overrun <= 1'b1;
`ifdef TB_OVERRUN_CNT_EN
                if (ovr_cnt != 8'hFF)
                    ovr_cnt <= ovr_cnt + 8'd1;
`endif
            end

            case (state)
                TRACE: begin
                    dec_int[step] <= tb_state[0];
                    tb_state      <= next_tb_state;
                    step          <= step + 3'd1;
                    if (step == 3'd7) begin
                        if (out_free) begin
                            dec_valid <= 1'b1;
                            dec_bits  <= {tb_state[0], dec_int[6:0]};
                            end_state <= next_tb_state;
                            state     <= IDLE;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        dec_valid <= 1'b1;
                        dec_bits  <= dec_int;
                        end_state <= tb_state;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase

            // A hand-off overrides the return to IDLE in the same cycle.
            if (handoff) begin
                trace_bank <= {data_in, cap_bank};
                tb_state   <= best_state;
                step       <= 3'd0;
                state      <= TRACE;
            end
        end
    end

endmodule

// File: tb/tb_tb_unit.sv
// Directed bench for tb_unit: fixed data patterns with hand-computed traceback
// results, stall/overrun, back-to-back frames against a traceback model, async reset.
module tb_tb_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_in = '0;
    logic [4:0]  best_state = '0;
    logic        dec_ready = 1'b0;
    logic        dec_valid;
    logic [7:0]  dec_bits;
    logic [4:0]  end_state;
    logic        overrun;
`ifdef TB_OVERRUN_CNT_EN
    logic [7:0]  ovr_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc;
    int mode = 0;
    logic [4:0] bs_tab [0:15];

    tb_unit dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .best_state (best_state),
        .dec_ready  (dec_ready),
        .dec_valid  (dec_valid),
        .dec_bits   (dec_bits),
        .end_state  (end_state),
`ifdef TB_OVERRUN_CNT_EN
        .ovr_cnt    (ovr_cnt),
`endif
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;

    function automatic logic [31:0] gen(input int m, input int frame, input int c);
        logic [31:0] w;
        case (m)
            0: gen = 32'h0;
            1: gen = 32'hFFFF_FFFF;
            2: gen = (c == 1) ? 32'h0000_0100 : 32'h0;
            default: begin
                w = (frame * 8 + c + 1) * 32'h9E37_79B1;
                gen = w ^ (w >> 13) ^ 32'h5A5A_3C3C;
            end
        endcase
    endfunction

    always @(negedge clk) begin
        data_in    = gen(mode, cyc / 8, cyc % 8);
        best_state = bs_tab[(cyc / 8) % 16];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Software traceback: state s -> column s/4, row s%4, bit k of that row byte.
    task automatic model(input int m, input int frame, input logic [4:0] bs,
                         output logic [7:0] bits, output logic [4:0] st);
        logic [31:0] w;
        int s;
        s = bs;
        bits = 8'h0;
        for (int k = 0; k < 8; k++) begin
            bits[k] = s[0];
            w = gen(m, frame, s / 4);
            s = (int'(w[(s % 4) * 8 + k]) << 4) | (s >> 1);
        end
        st = s[4:0];
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("wait_cyc", cyc, n);
    endtask

    task automatic do_reset(input int m, input logic rdy);
        rst = 1'b0;
        mode = m;
        dec_ready = rdy;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] mbits;
        logic [4:0] mst;

        for (int i = 0; i < 16; i++) bs_tab[i] = 5'b10110;

        // Reset state
        do_reset(0, 1'b1);
        check("rst_valid", dec_valid, 0);
        check("rst_bits", dec_bits, 0);
        check("rst_end", end_state, 0);
        check("rst_ovr", overrun, 0);

        // All-zero data, best_state 10110
        wait_cyc(15);
        check("z_valid_early", dec_valid, 0);
        wait_cyc(16);
        check("z_valid", dec_valid, 1);
        check("z_bits", dec_bits, 8'h16);
        check("z_end", end_state, 5'd0);
        check("z_ovr", overrun, 0);

        // All-ones data, best_state 0
        for (int i = 0; i < 16; i++) bs_tab[i] = 5'd0;
        do_reset(1, 1'b1);
        wait_cyc(16);
        check("o_valid", dec_valid, 1);
        check("o_bits", dec_bits, 8'hE0);
        check("o_end", end_state, 5'b11111);

        // Single history bit h[5][0], best_state 5
        for (int i = 0; i < 16; i++) bs_tab[i] = 5'd5;
        do_reset(2, 1'b1);
        wait_cyc(16);
        check("h5_valid", dec_valid, 1);
        check("h5_bits", dec_bits, 8'h25);
        check("h5_end", end_state, 5'd0);

        // Stall: frame1 waits in HOLD, frame2 dropped
        for (int i = 0; i < 16; i++) bs_tab[i] = 5'b10110;
        bs_tab[1] = 5'd1;
        do_reset(0, 1'b0);
        wait_cyc(16);
        check("st_valid", dec_valid, 1);
        check("st_bits", dec_bits, 8'h16);
        wait_cyc(23);
        check("st_hold_valid", dec_valid, 1);
        check("st_hold_bits", dec_bits, 8'h16);
        check("st_ovr_pre", overrun, 0);
        wait_cyc(24);
        check("st_ovr", overrun, 1);
        check("st_stable_bits", dec_bits, 8'h16);
`ifdef TB_OVERRUN_CNT_EN
        check("st_ovr_cnt", ovr_cnt, 8'd1);
`endif
        wait_cyc(28);
        dec_ready = 1'b1;
        wait_cyc(29);
        check("st_f1_valid", dec_valid, 1);
        check("st_f1_bits", dec_bits, 8'h01);
        check("st_f1_end", end_state, 5'd0);
        wait_cyc(30);
        check("st_drain", dec_valid, 0);
        wait_cyc(40);
        check("st_f3_valid", dec_valid, 1);
        check("st_f3_bits", dec_bits, 8'h16);
        check("st_ovr_sticky", overrun, 1);

        // Ten back-to-back frames against the model
        for (int i = 0; i < 16; i++) bs_tab[i] = 5'((i * 7 + 3) % 32);
        do_reset(3, 1'b1);
        for (int f = 0; f < 10; f++) begin
            wait_cyc(8 * f + 15);
            check("bb_gap", dec_valid, 0);
            wait_cyc(8 * f + 16);
            model(3, f, bs_tab[f], mbits, mst);
            check("bb_valid", dec_valid, 1);
            check("bb_bits", dec_bits, mbits);
            check("bb_end", end_state, mst);
        end
        check("bb_ovr", overrun, 0);

        // Async reset during TRACE stage 3 of frame 1
        for (int i = 0; i < 16; i++) bs_tab[i] = 5'b10110;
        do_reset(0, 1'b0);
        wait_cyc(19);
        check("mr_pre_valid", dec_valid, 1);
        rst = 1'b0;
        #1;
        check("mr_valid", dec_valid, 0);
        check("mr_bits", dec_bits, 0);
        check("mr_end", end_state, 0);
        check("mr_ovr", overrun, 0);
        @(negedge clk);
        dec_ready = 1'b1;
        rst = 1'b1;
        wait_cyc(15);
        check("mr_valid_early", dec_valid, 0);
        wait_cyc(16);
        check("mr_valid_post", dec_valid, 1);
        check("mr_bits_post", dec_bits, 8'h16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
